mem_access_unit: RTL and testbench

Load/store engine between the core datapath and the external RAM port. It replaces the fixed-word, ready-less fetch path with a parametrised sequencer. The sequencer issues one access per request, applies byte enables, and waits on a ready handshake with a timeout. It returns zero- or sign-extended byte/halfword/word(/doubleword) read data and flags misaligned or timed-out accesses. It sits beside the register bank. The state machine drives req and consumes done/fault/rdata in place of MRDR/MWDR loading.

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Core/RAM-side signal bundle for mem_access_unit.
// slave = the access unit's view, master = the core plus RAM side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  busy;
  logic                  done;
  logic                  fault;
  logic [DATA_W-1:0]     rdata;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  req, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata, mem_ready,
    output busy, done, fault, rdata, mem_addr, mem_wdata, mem_be, mem_cs, mem_we, mem_oe
  );

  modport master (
    output req, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata, mem_ready,
    input  busy, done, fault, rdata, mem_addr, mem_wdata, mem_be, mem_cs, mem_we, mem_oe
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one RAM access per request, byte enables, ready timeout, load extension.
// Optional MAU_ROTATE_UNALIGNED_EN: unaligned word loads fetch the aligned word and rotate it right.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam int NL = DATA_W / 8;
  localparam int LW = $clog2(NL);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state;
  logic              we_r;
  logic [1:0]        size_r;
  logic              sgn_r;
  logic [LW-1:0]     lane_r;
  logic [NL-1:0]     be_r;
  logic [7:0]        cnt_r;
  logic              fault_r;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  logic [LW-1:0]     lo;
  logic [LW-1:0]     base_n;
  logic [NL-1:0]     be_n;
  logic [DATA_W-1:0] wrep_n;
  logic              bad_n;
  logic [DATA_W-1:0] sh;
  logic [31:0]       w;
  logic [DATA_W-1:0] ld_ext;
`ifdef MAU_ROTATE_UNALIGNED_EN
  logic [1:0]        rot_n;
  logic [1:0]        rot_r;
`endif

  // Request decode: lane base, byte enables, replicated store data, alignment fault.
  always_comb begin
    lo     = bus.req_addr[LW-1:0];
    base_n = '0;
    be_n   = '0;
    wrep_n = '0;
    bad_n  = 1'b0;
`ifdef MAU_ROTATE_UNALIGNED_EN
    rot_n  = '0;
`endif
    case (bus.req_size)
      2'b00: begin
        base_n = lo;
        be_n   = NL'(1) << lo;
        for (int unsigned i = 0; i < NL; i++) wrep_n[8*i +: 8] = bus.req_wdata[7:0];
      end
      2'b01: begin
        bad_n  = lo[0];
        base_n = {lo[LW-1:1], 1'b0};
        be_n   = NL'(3) << base_n;
        for (int unsigned i = 0; i < NL/2; i++) wrep_n[16*i +: 16] = bus.req_wdata[15:0];
      end
      2'b10: begin
        bad_n  = |lo[1:0];
        base_n = lo & ~LW'(3);
        be_n   = NL'(15) << base_n;
        for (int unsigned i = 0; i < NL/4; i++) wrep_n[32*i +: 32] = bus.req_wdata[31:0];
`ifdef MAU_ROTATE_UNALIGNED_EN
        if (!bus.req_we) begin
          bad_n = 1'b0;
          rot_n = lo[1:0];
        end
`endif
      end
      default: begin
        bad_n  = (DATA_W == 32) || (|bus.req_addr[2:0]);
        be_n   = '1;
        wrep_n = bus.req_wdata;
      end
    endcase
  end

  // Load path: shift the addressed lanes down to bit 0, then extend.
  always_comb begin
    sh = bus.mem_rdata >> {lane_r, 3'b000};
    w  = sh[31:0];
`ifdef MAU_ROTATE_UNALIGNED_EN
    w  = (w >> {rot_r, 3'b000}) | (w << (6'd32 - {1'b0, rot_r, 3'b000}));
`endif
    case (size_r)
      2'b00:   ld_ext = sgn_r ? DATA_W'($signed(sh[7:0]))  : DATA_W'(sh[7:0]);
      2'b01:   ld_ext = sgn_r ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0]);
      2'b10:   ld_ext = DATA_W'(w);
      default: ld_ext = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      we_r    <= 1'b0;
      size_r  <= '0;
      sgn_r   <= 1'b0;
      lane_r  <= '0;
      be_r    <= '0;
      cnt_r   <= '0;
      fault_r <= 1'b0;
      rdata_r <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
`ifdef MAU_ROTATE_UNALIGNED_EN
      rot_r   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            we_r    <= bus.req_we;
            size_r  <= bus.req_size;
            sgn_r   <= bus.req_signed;
            lane_r  <= base_n;
            be_r    <= be_n;
            cnt_r   <= '0;
            fault_r <= bad_n;
`ifdef MAU_ROTATE_UNALIGNED_EN
            rot_r   <= rot_n;
`endif
            if (bad_n) begin
              state <= S_DONE;
            end else begin
              addr_r  <= {bus.req_addr[ADDR_W-1:LW], LW'(0)};
              wdata_r <= wrep_n;
              state   <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (bus.mem_ready) begin
            if (!we_r) rdata_r <= ld_ext;
            fault_r <= 1'b0;
            state   <= S_DONE;
          end else if (cnt_r == 8'(TIMEOUT - 1)) begin
            fault_r <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state so an async reset drops them immediately.
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.fault     = (state == S_DONE) && fault_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_cs    = (state == S_ACCESS);
  assign bus.mem_we    = (state == S_ACCESS) && we_r;
  assign bus.mem_oe    = (state == S_ACCESS) && !we_r;
  assign bus.mem_be    = (state == S_ACCESS) ? be_r : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (DATA_W=32, TIMEOUT=4).
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [32:0] sb[$];
  logic [31:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        automatic logic [32:0] e = sb.pop_front();
        check("rdata", bus.rdata, e[31:0]);
        check("fault", 32'(bus.fault), 32'(e[32]));
      end
    end
  end

  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mdata, input int unsigned waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd, input logic exp_fault,
                           input logic strobe);
    @(negedge clk);
    bus.req        = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    sb.push_back({exp_fault, exp_rd});
    @(negedge clk);
    bus.req = 1'b0;
    if (!strobe) begin
      check("no_strobe_cs", 32'(bus.mem_cs), 32'd0);
      check("early_done", 32'(bus.done), 32'd1);
      return;
    end
    check("cs", 32'(bus.mem_cs), 32'd1);
    check("be", 32'(bus.mem_be), 32'(exp_be));
    check("we", 32'(bus.mem_we), 32'(we));
    check("oe", 32'(bus.mem_oe), 32'(!we));
    check("addr", bus.mem_addr, addr & ~32'd3);
    if (we) check("wdata", bus.mem_wdata, exp_wd);
    for (int unsigned i = 0; i < waits; i++) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = ~mdata;
      bus.req       = (i == 0);   // ignored while busy
      bus.req_addr  = 32'h0000_0300;
      @(negedge clk);
      bus.req = 1'b0;
      check("be_stable", 32'(bus.mem_be), 32'(exp_be));
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = mdata;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check("latency_done", 32'(bus.done), 32'd1);
    check("strobe_off", 32'(bus.mem_cs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cs_cnt;
    int seen_done;
    int done_before;
    bus.req = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_cs", 32'(bus.mem_cs), 32'd0);
    check("rst_be", 32'(bus.mem_be), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_maddr", bus.mem_addr, 32'd0);
    check("rst_mwdata", bus.mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_access(0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0, 4'b1111, 0, 32'hDEADBEEF, 0, 1);
    last_rd = 32'hDEADBEEF;
    do_access(0, 2'b00, 1, 32'h103, 0, 32'h80123456, 0, 4'b1000, 0, 32'hFFFFFF80, 0, 1);
    do_access(0, 2'b00, 0, 32'h103, 0, 32'h80123456, 1, 4'b1000, 0, 32'h00000080, 0, 1);
    last_rd = 32'h00000080;
    do_access(1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 0, 4'b1100, 32'hABCDABCD, last_rd, 0, 1);
    do_access(0, 2'b01, 1, 32'h102, 0, 32'h87651234, 2, 4'b1100, 0, 32'hFFFF8765, 0, 1);
    do_access(0, 2'b01, 1, 32'h100, 0, 32'h87651234, 0, 4'b0011, 0, 32'h00001234, 0, 1);
    last_rd = 32'h00001234;
    do_access(1, 2'b00, 0, 32'h101, 32'h0000005A, 32'h0, 1, 4'b0010, 32'h5A5A5A5A, last_rd, 0, 1);
`ifdef MAU_ROTATE_UNALIGNED_EN
    do_access(0, 2'b10, 0, 32'h101, 0, 32'h11223344, 0, 4'b1111, 0, 32'h44112233, 0, 1);
    last_rd = 32'h44112233;
`else
    do_access(0, 2'b10, 0, 32'h101, 0, 32'h11223344, 0, 4'b0000, 0, last_rd, 1, 0);
`endif
    do_access(0, 2'b01, 0, 32'h103, 0, 32'h0, 0, 4'b0000, 0, last_rd, 1, 0);
    do_access(0, 2'b11, 0, 32'h100, 0, 32'h0, 0, 4'b0000, 0, last_rd, 1, 0);
    do_access(1, 2'b10, 0, 32'h102, 32'h1234, 32'h0, 0, 4'b0000, 0, last_rd, 1, 0);

    // Timeout: ready held low.
    @(negedge clk);
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h40;
    sb.push_back({1'b1, last_rd});
    cs_cnt = 0;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.req = 1'b0;
      if (bus.done) begin
        seen_done = 1;
        break;
      end
      cs_cnt += int'(bus.mem_cs);
    end
    check("timeout_done_seen", 32'(seen_done), 32'd1);
    check("timeout_cs_cycles", 32'(cs_cnt), 32'd4);
    @(negedge clk);
    check("timeout_idle", 32'(bus.busy), 32'd0);

    // Reset during the second wait cycle.
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h20;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    check("pre_rst_cs", 32'(bus.mem_cs), 32'd1);
    done_before = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_mid_cs", 32'(bus.mem_cs), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_done", 32'(done_cnt), 32'(done_before));
    last_rd = 32'h0;
    check("rst_rdata_clr", bus.rdata, last_rd);

    do_access(0, 2'b10, 0, 32'h10, 0, 32'hCAFEF00D, 1, 4'b1111, 0, 32'hCAFEF00D, 0, 1);
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
